// File: rtl/sar_search_if.sv
// Handshake and comparator bus for the SAR binary-search controller.
//   start   : request a new search (driven by the requester)
//   trial   : current trial value, feeds the b operand of the external comparator
//   cmp_lt/cmp_eq/cmp_gt : comparator result for target vs trial
//   busy/done : search in progress / one-cycle completion pulse
//   result/found/error/steps : outcome of the last search, held until the next start
// master: requester plus comparator side; slave: the search engine.
interface sar_search_if #(
   parameter int unsigned N = 8
);
   localparam int unsigned StepsW = $clog2(N + 2);

   logic              start;
   logic [N-1:0]      trial;
   logic              cmp_lt;
   logic              cmp_eq;
   logic              cmp_gt;
   logic              busy;
   logic              done;
   logic [N-1:0]      result;
   logic              found;
   logic              error;
   logic [StepsW-1:0] steps;

   modport master (
      output start, cmp_lt, cmp_eq, cmp_gt,
      input  trial, busy, done, result, found, error, steps
   );

   modport slave (
      input  start, cmp_lt, cmp_eq, cmp_gt,
      output trial, busy, done, result, found, error, steps
   );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation binary search against an external magnitude comparator.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : sar_search_if slave modport (start, trial, cmp_*, busy, done, result,
//         found, error, steps)
// One comparison is consumed per EVAL cycle. Inconsistent or non-one-hot comparator
// answers, and bound updates that would wrap or cross, abort the search with error=1.
module sar_search #(
   parameter int unsigned N = 8
) (
   input logic        clk,
   input logic        rst,
   sar_search_if.slave bus
);
   localparam int unsigned StepsW = $clog2(N + 2);
   localparam logic [N-1:0] MaxVal = '1;

   typedef enum logic [1:0] {StIdle, StEval, StFinish} state_e;

   state_e            state_q, state_d;
   logic [N-1:0]      lo_q, lo_d;
   logic [N-1:0]      hi_q, hi_d;
   logic [N-1:0]      trial_q, trial_d;
   logic [N-1:0]      result_q, result_d;
   logic [StepsW-1:0] steps_q, steps_d;
   logic              found_q, found_d;
   logic              error_q, error_d;
   logic              done_q, done_d;

   logic [N-1:0]      new_lo, new_hi;
   logic              abort;
   logic [2:0]        cmp_vec;

   assign cmp_vec = {bus.cmp_lt, bus.cmp_eq, bus.cmp_gt};

   always_comb begin
      state_d  = state_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      trial_d  = trial_q;
      result_d = result_q;
      steps_d  = steps_q;
      found_d  = found_q;
      error_d  = error_q;
      done_d   = (state_q == StFinish);
      new_lo   = lo_q;
      new_hi   = hi_q;
      abort    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               lo_d    = '0;
               hi_d    = MaxVal;
               trial_d = MaxVal >> 1;
               steps_d = '0;
               found_d = 1'b0;
               error_d = 1'b0;
               state_d = StEval;
            end
         end
         StEval: begin
            steps_d = steps_q + StepsW'(1);
            case (cmp_vec)
               3'b010: begin
                  result_d = trial_q;
                  found_d  = 1'b1;
                  state_d  = StFinish;
               end
               3'b001: begin
                  // target above trial: raise lo, refusing to wrap past MaxVal
                  if (trial_q == MaxVal) begin
                     abort = 1'b1;
                  end else begin
                     new_lo = trial_q + N'(1);
                     if (new_lo > hi_q) abort = 1'b1;
                  end
               end
               3'b100: begin
                  // target below trial: lower hi, refusing to wrap below zero
                  if (trial_q == '0) begin
                     abort = 1'b1;
                  end else begin
                     new_hi = trial_q - N'(1);
                     if (new_hi < lo_q) abort = 1'b1;
                  end
               end
               default: abort = 1'b1;
            endcase

            if (abort) begin
               result_d = trial_q;
               error_d  = 1'b1;
               found_d  = 1'b0;
               state_d  = StFinish;
            end else if (cmp_vec != 3'b010) begin
               lo_d    = new_lo;
               hi_d    = new_hi;
               // midpoint form that cannot overflow N bits
               trial_d = new_lo + ((new_hi - new_lo) >> 1);
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         lo_q     <= '0;
         hi_q     <= MaxVal;
         trial_q  <= '0;
         result_q <= '0;
         steps_q  <= '0;
         found_q  <= 1'b0;
         error_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         trial_q  <= trial_d;
         result_q <= result_d;
         steps_q  <= steps_d;
         found_q  <= found_d;
         error_q  <= error_d;
         done_q   <= done_d;
      end
   end

   assign bus.trial  = trial_q;
   assign bus.busy   = (state_q != StIdle);
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.found  = found_q;
   assign bus.error  = error_q;
   assign bus.steps  = steps_q;
endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search (N=8) with a behavioural comparator and a
// reference model of the binary search written with plain integer arithmetic.
module tb_sar_search;
   localparam int unsigned N = 8;

   logic clk;
   logic rst;
   int   mode;    // 0: honest comparator, 1: always gt, 2: lt and gt together
   int   target;
   int   total;
   int   fails;
   int   exp_q[$];

   sar_search_if #(.N(N)) bus ();

   sar_search #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      bus.cmp_lt = 1'b0;
      bus.cmp_eq = 1'b0;
      bus.cmp_gt = 1'b0;
      case (mode)
         1: bus.cmp_gt = 1'b1;
         2: begin
            bus.cmp_lt = 1'b1;
            bus.cmp_gt = 1'b1;
         end
         default: begin
            bus.cmp_lt = (target < int'(bus.trial));
            bus.cmp_eq = (target == int'(bus.trial));
            bus.cmp_gt = (target > int'(bus.trial));
         end
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Expected trial sequence for an honest comparator: classic halving search.
   task automatic model_honest(input int tgt);
      int lo, hi, t;
      exp_q.delete();
      lo = 0;
      hi = 255;
      forever begin
         t = lo + (hi - lo) / 2;
         exp_q.push_back(t);
         if (t == tgt) break;
         if (tgt > t) lo = t + 1;
         else hi = t - 1;
      end
   endtask

   // Expected trials when the comparator always claims target > trial.
   task automatic model_gt();
      int lo, hi, t;
      exp_q.delete();
      lo = 0;
      hi = 255;
      forever begin
         t = lo + (hi - lo) / 2;
         exp_q.push_back(t);
         if (t == 255) break;
         lo = t + 1;
         if (lo > hi) break;
      end
   endtask

   task automatic launch(input bit hold);
      bus.start = 1'b1;
      tick();
      if (!hold) bus.start = 1'b0;
   endtask

   // Called one cycle after the start cycle; follows the search up to done.
   task automatic track(input string tag, input bit chk_tr, input int er, input int ef,
                        input int ee, input int es, input bit chk_steps);
      int  c;
      bit  seen;
      c = 1;
      seen = 1'b0;
      while (c < 40 && !seen) begin
         if (bus.done) begin
            seen = 1'b1;
         end else begin
            if (chk_tr && c <= exp_q.size()) chk({tag, " trial"}, 32'(bus.trial), exp_q[c-1]);
            tick();
            c++;
         end
      end
      chk({tag, " done seen"}, 32'(seen), 1);
      if (seen) begin
         chk({tag, " latency"}, c, 32'(int'(bus.steps) + 2));
         chk({tag, " result"}, 32'(bus.result), er);
         chk({tag, " found"}, 32'(bus.found), ef);
         chk({tag, " error"}, 32'(bus.error), ee);
         if (chk_steps) chk({tag, " steps"}, 32'(bus.steps), es);
         else chk({tag, " steps<=9"}, 32'(bus.steps <= 4'd9), 1);
         chk({tag, " busy in done"}, 32'(bus.busy), 0);
      end
   endtask

   task automatic honest_search(input string tag, input int tgt, input bit chk_tr);
      mode = 0;
      target = tgt;
      model_honest(tgt);
      launch(1'b0);
      track(tag, chk_tr, tgt, 1, 0, exp_q.size(), chk_tr);
   endtask

   initial begin
      total = 0;
      fails = 0;
      mode = 0;
      target = 0;
      bus.start = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      chk("rst trial", 32'(bus.trial), 0);
      chk("rst busy", 32'(bus.busy), 0);
      chk("rst done", 32'(bus.done), 0);
      chk("rst result", 32'(bus.result), 0);
      chk("rst found", 32'(bus.found), 0);
      chk("rst error", 32'(bus.error), 0);
      chk("rst steps", 32'(bus.steps), 0);
      rst = 1'b0;
      tick();
      chk("idle busy", 32'(bus.busy), 0);

      // directed targets
      honest_search("t127", 127, 1'b1);
      chk("t127 steps", 32'(bus.steps), 1);
      honest_search("t0", 0, 1'b1);
      chk("t0 steps", 32'(bus.steps), 8);
      honest_search("t255", 255, 1'b1);
      chk("t255 steps", 32'(bus.steps), 9);

      // trial holds while idle, done is a single pulse
      tick();
      chk("idle done low", 32'(bus.done), 0);
      tick();
      chk("idle trial hold", 32'(bus.trial), 255);
      chk("idle result hold", 32'(bus.result), 255);

      // comparator always says greater: runs off the top
      mode = 1;
      model_gt();
      launch(1'b0);
      track("gt", 1'b1, 255, 0, 1, 9, 1'b1);

      // lt and gt both set on the first compare
      mode = 2;
      exp_q.delete();
      exp_q.push_back(127);
      launch(1'b0);
      track("ltgt", 1'b1, 127, 0, 1, 1, 1'b1);

      // reset during the third EVAL cycle
      mode = 0;
      target = 200;
      launch(1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst trial", 32'(bus.trial), 0);
      chk("midrst busy", 32'(bus.busy), 0);
      chk("midrst done", 32'(bus.done), 0);
      chk("midrst result", 32'(bus.result), 0);
      chk("midrst found", 32'(bus.found), 0);
      chk("midrst error", 32'(bus.error), 0);
      chk("midrst steps", 32'(bus.steps), 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("midrst no done", 32'(bus.done), 0);
      end
      honest_search("post rst", 200, 1'b1);

      // reset wins over start in the same cycle
      bus.start = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.start = 1'b0;
      chk("rst prio busy", 32'(bus.busy), 0);
      tick();
      chk("rst prio idle", 32'(bus.busy), 0);

      // start held high: ignored mid-search, accepted on the done cycle
      mode = 0;
      target = 77;
      model_honest(77);
      launch(1'b1);
      track("hold", 1'b1, 77, 1, 0, exp_q.size(), 1'b1);
      tick();
      bus.start = 1'b0;
      chk("hold restart busy", 32'(bus.busy), 1);
      chk("hold restart trial", 32'(bus.trial), 127);
      chk("hold restart steps", 32'(bus.steps), 0);
      chk("hold restart found", 32'(bus.found), 0);
      chk("hold restart done", 32'(bus.done), 0);
      track("hold2", 1'b1, 77, 1, 0, exp_q.size(), 1'b1);

      // random targets with full trial tracking
      for (int i = 0; i < 30; i++) begin
         honest_search("rand", int'($urandom_range(0, 255)), 1'b1);
      end

      // exhaustive sweep
      for (int t = 0; t < 256; t++) begin
         honest_search("sweep", t, 1'b0);
      end

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter N, default 8, operand width in bits; the block SHALL support N >= 2.
REQ-002 clk  input  1  rising-edge clock; all state SHALL change only on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a new search; accepted only when busy=0.
REQ-005 trial  output  N  registered trial value, driven to the b operand of an external combinational magnitude comparator whose a operand is the unknown target.
REQ-006 cmp_lt  input  1  comparator result target < trial.
REQ-007 cmp_eq  input  1  comparator result target == trial.
REQ-008 cmp_gt  input  1  comparator result target > trial.
REQ-009 busy  output  1  high while a search is in progress.
REQ-010 done  output  1  one-cycle pulse marking search completion.
REQ-011 result  output  N  final trial value; held until the next accepted start.
REQ-012 found  output  1  high with done when the search ended on cmp_eq; held with result.
REQ-013 error  output  1  high with done when the search aborted; held with result.
REQ-014 steps  output  clog2(N+2)  number of comparisons consumed; held with result.

Function
REQ-015 States SHALL be IDLE, EVAL and FINISH; reset state SHALL be IDLE.
REQ-016 IDLE: busy=0; start=1 SHALL load lo=0, hi=2^N-1, trial=(2^N-1)>>1, steps=0, clear found/error, and go to EVAL.
REQ-017 EVAL: busy=1; trial SHALL be stable for the whole cycle; cmp_* SHALL be sampled at the end of the cycle; each EVAL cycle SHALL increment steps by 1 (one comparison per cycle).
REQ-018 cmp_eq only: result=trial, found=1, go to FINISH.
REQ-019 cmp_gt only: lo=trial+1; cmp_lt only: hi=trial-1; next trial SHALL be lo+((hi-lo)>>1) using the updated bounds; stay in EVAL.
REQ-020 Bound arithmetic SHALL be overflow-free: cmp_gt with trial=2^N-1, cmp_lt with trial=0, or any update giving lo>hi SHALL abort with result=trial, error=1, found=0, then go to FINISH.
REQ-021 cmp_lt/cmp_eq/cmp_gt not exactly one-hot when sampled SHALL abort as in REQ-020.
REQ-022 FINISH: busy=1 for one cycle, then IDLE; done SHALL be high for exactly the first IDLE cycle after FINISH, with result/found/error/steps valid.
REQ-023 start in EVAL or FINISH SHALL be ignored; start in the cycle done=1 SHALL be accepted.
REQ-024 With a consistent comparator the search SHALL terminate with found=1 in at most N+1 comparisons; latency from the start cycle to done SHALL be steps+2 cycles.
REQ-025 trial SHALL hold its last value while IDLE.

Reset
REQ-026 rst=1 SHALL force IDLE in the next cycle regardless of state, including mid-search, with trial=0, busy=0, done=0, result=0, found=0, error=0, steps=0.
REQ-027 rst SHALL take priority over start in the same cycle.
REQ-028 Bound registers lo and hi SHALL be reset to 0 and 2^N-1 respectively.

Verification (N=8, bench models comparator against target)
REQ-029 target=127, start at cycle 0 -> trial=127 at cycle 1, done at cycle 3, result=127, found=1, steps=1.
REQ-030 target=255 -> trials 127,191,223,239,247,251,253,254,255, found=1, steps=9, done 11 cycles after start.
REQ-031 target=0 -> trials 127,63,31,15,7,3,1,0, found=1, steps=8.
REQ-032 comparator forced cmp_gt=1 always -> error=1, found=0, result=255, steps=9; then cmp_lt=cmp_gt=1 on the first compare -> error=1, result=127, steps=1.
REQ-033 rst pulsed on the 3rd EVAL cycle -> all outputs at reset values the next cycle, with no done pulse; a new start then completes normally.
REQ-034 start held high for a whole search -> the second search begins in the done cycle and start during EVAL or FINISH is ignored; exhaustive target sweep 0..255 -> found=1 and steps<=9 for every target.
